// File: rtl/alu_ctrl_pkg.sv
// Shared constants, field positions and helpers for the ALU control unit.
package alu_ctrl_pkg;

    localparam int DATA_W    = 8;
    localparam int REG_COUNT = 8;
    localparam int ADDR_W    = 3;
    localparam int INSTR_W   = 32;

    localparam int OP_MSB   = 31;
    localparam int OP_LSB   = 24;
    localparam int DEST_MSB = 23;
    localparam int DEST_LSB = 16;
    localparam int SRC1_MSB = 15;
    localparam int SRC1_LSB = 8;
    localparam int SRC2_MSB = 7;
    localparam int SRC2_LSB = 0;

    localparam logic [7:0] OP_LOADI = 8'd0;
    localparam logic [7:0] OP_MOV   = 8'd1;
    localparam logic [7:0] OP_ADD   = 8'd2;
    localparam logic [7:0] OP_SUB   = 8'd3;
    localparam logic [7:0] OP_AND   = 8'd4;
    localparam logic [7:0] OP_OR    = 8'd5;

    localparam logic [2:0] ALU_FWD = 3'b000;
    localparam logic [2:0] ALU_ADD = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_WB   = 2'd2
    } state_e;

    // Two's-complement negation; 0x80 maps onto itself.
    function automatic logic [DATA_W-1:0] negate(input logic [DATA_W-1:0] v);
        return (~v) + 8'd1;
    endfunction

    function automatic logic op_legal(input logic [7:0] op);
        return (op <= OP_OR);
    endfunction

endpackage

// File: rtl/alu_ctrl_unit_reg_file.sv
// 8x8 register file: two operand read ports, a debug read port, one write port.
module reg_file
    import alu_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr_a,
    output logic [DATA_W-1:0] rdata_a,
    input  logic [ADDR_W-1:0] raddr_b,
    output logic [DATA_W-1:0] rdata_b,
    input  logic [ADDR_W-1:0] raddr_dbg,
    output logic [DATA_W-1:0] rdata_dbg
);

    logic [DATA_W-1:0] regs_q [REG_COUNT];
    logic [DATA_W-1:0] regs_d [REG_COUNT];

    // Next register contents: only the addressed entry changes on a write.
    always_comb begin
        regs_d = regs_q;
        if (we) begin
            regs_d[waddr] = wdata;
        end else begin
            regs_d = regs_q;
        end
    end

    // Register storage, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < REG_COUNT; i++) begin
                regs_q[i] <= {DATA_W{1'b0}};
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    assign rdata_a   = regs_q[raddr_a];
    assign rdata_b   = regs_q[raddr_b];
    assign rdata_dbg = regs_q[raddr_dbg];

endmodule

// File: rtl/alu_ctrl_unit.sv
// Three-state sequencer driving an external ALU and writing its result back.
module alu_ctrl_unit
    import alu_ctrl_pkg::*;
(
    input  logic               CLK,
    input  logic               RESET_N,
    input  logic               INSTR_VALID,
    output logic               INSTR_READY,
    input  logic [INSTR_W-1:0] INSTRUCTION,
    output logic [2:0]         ALUOP,
    output logic [DATA_W-1:0]  OPERAND1,
    output logic [DATA_W-1:0]  OPERAND2,
    input  logic [DATA_W-1:0]  ALURESULT,
    output logic               WB_VALID,
    output logic [ADDR_W-1:0]  WB_ADDR,
    output logic [DATA_W-1:0]  WB_DATA,
    output logic               ILLEGAL,
    input  logic [ADDR_W-1:0]  REG_RADDR,
    output logic [DATA_W-1:0]  REG_RDATA
);

    state_e             state_q, state_d;
    logic [7:0]         op_q, op_d;
    logic [ADDR_W-1:0]  dest_q, dest_d;
    logic               ready_q, ready_d;
    logic [2:0]         aluop_q, aluop_d;
    logic [DATA_W-1:0]  op1_q, op1_d;
    logic [DATA_W-1:0]  op2_q, op2_d;
    logic               wb_valid_q, wb_valid_d;
    logic [ADDR_W-1:0]  wb_addr_q, wb_addr_d;
    logic [DATA_W-1:0]  wb_data_q, wb_data_d;
    logic               illegal_q, illegal_d;

    logic [7:0]         op_in_s;
    logic [DATA_W-1:0]  imm_in_s;
    logic [DATA_W-1:0]  rdata_a_s, rdata_b_s;
    logic               unused_bits_s;

    assign op_in_s       = INSTRUCTION[OP_MSB:OP_LSB];
    assign imm_in_s      = INSTRUCTION[SRC2_MSB:SRC2_LSB];
    assign unused_bits_s = ^{INSTRUCTION[DEST_MSB:DEST_LSB+ADDR_W],
                             INSTRUCTION[SRC1_MSB:SRC1_LSB+ADDR_W]};

    // Operands are fetched at the accepting edge so they are stable for all of EXEC.
    reg_file u_reg_file (
        .clk       (CLK),
        .rst_n     (RESET_N),
        .we        (wb_valid_q),
        .waddr     (wb_addr_q),
        .wdata     (wb_data_q),
        .raddr_a   (INSTRUCTION[SRC1_LSB +: ADDR_W]),
        .rdata_a   (rdata_a_s),
        .raddr_b   (INSTRUCTION[SRC2_LSB +: ADDR_W]),
        .rdata_b   (rdata_b_s),
        .raddr_dbg (REG_RADDR),
        .rdata_dbg (REG_RDATA)
    );

    // Next-state, decode and output computation.
    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        dest_d     = dest_q;
        aluop_d    = aluop_q;
        op1_d      = op1_q;
        op2_d      = op2_q;
        wb_valid_d = 1'b0;
        wb_addr_d  = wb_addr_q;
        wb_data_d  = wb_data_q;
        illegal_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (INSTR_VALID && ready_q) begin
                    state_d   = ST_EXEC;
                    op_d      = op_in_s;
                    dest_d    = INSTRUCTION[DEST_LSB +: ADDR_W];
                    illegal_d = !op_legal(op_in_s);
                    if (op_legal(op_in_s)) begin
                        op1_d = rdata_a_s;
                    end else begin
                        op1_d = op1_q;
                    end
                    case (op_in_s)
                        OP_LOADI: begin aluop_d = ALU_FWD; op2_d = imm_in_s;          end
                        OP_MOV:   begin aluop_d = ALU_FWD; op2_d = rdata_b_s;         end
                        OP_ADD:   begin aluop_d = ALU_ADD; op2_d = rdata_b_s;         end
                        OP_SUB:   begin aluop_d = ALU_ADD; op2_d = negate(rdata_b_s); end
                        OP_AND:   begin aluop_d = ALU_AND; op2_d = rdata_b_s;         end
                        OP_OR:    begin aluop_d = ALU_OR;  op2_d = rdata_b_s;         end
                        default:  begin aluop_d = aluop_q; op2_d = op2_q;             end
                    endcase
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_EXEC: begin
                if (op_legal(op_q)) begin
                    state_d    = ST_WB;
                    wb_valid_d = 1'b1;
                    wb_addr_d  = dest_q;
                    wb_data_d  = ALURESULT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WB: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        ready_d = (state_d == ST_IDLE);
    end

    // State and registered outputs.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q    <= ST_IDLE;
            op_q       <= 8'd0;
            dest_q     <= 3'd0;
            ready_q    <= 1'b1;
            aluop_q    <= ALU_FWD;
            op1_q      <= 8'd0;
            op2_q      <= 8'd0;
            wb_valid_q <= 1'b0;
            wb_addr_q  <= 3'd0;
            wb_data_q  <= 8'd0;
            illegal_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            dest_q     <= dest_d;
            ready_q    <= ready_d;
            aluop_q    <= aluop_d;
            op1_q      <= op1_d;
            op2_q      <= op2_d;
            wb_valid_q <= wb_valid_d;
            wb_addr_q  <= wb_addr_d;
            wb_data_q  <= wb_data_d;
            illegal_q  <= illegal_d;
        end
    end

    assign INSTR_READY = ready_q;
    assign ALUOP       = aluop_q;
    assign OPERAND1    = op1_q;
    assign OPERAND2    = op2_q;
    assign WB_VALID    = wb_valid_q;
    assign WB_ADDR     = wb_addr_q;
    assign WB_DATA     = wb_data_q;
    assign ILLEGAL     = illegal_q;

endmodule
